// File: rtl/down_counter_if.sv
// Control/status bundle for the loadable down counter.
// Master drives load/enable/mode; slave returns count, tc and busy.
interface down_counter_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;

    modport master (
        output load,
        output load_val,
        output en,
        output auto_reload,
        input  count,
        input  tc,
        input  busy
    );

    modport slave (
        input  load,
        input  load_val,
        input  en,
        input  auto_reload,
        output count,
        output tc,
        output busy
    );
endinterface

// File: rtl/down_counter.sv
// Loadable, enable-gated down counter with one-cycle terminal-count pulse.
// One-shot or auto-reload; all outputs registered.
module down_counter #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    down_counter_if.slave       bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             tc_q;
    logic             busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (bus.load) begin
                // A load drops any terminal count pending on this edge.
                count_q  <= bus.load_val;
                reload_q <= bus.load_val;
                if (bus.load_val != ZERO) begin
                    state_q <= RUN;
                    busy_q  <= 1'b1;
                end else begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            end else begin
                case (state_q)
                    RUN: begin
                        if (bus.en) begin
                            if (count_q == ONE) begin
                                tc_q <= 1'b1;
                                if (bus.auto_reload) begin
                                    count_q <= reload_q;
                                end else begin
                                    count_q <= ZERO;
                                    state_q <= IDLE;
                                    busy_q  <= 1'b0;
                                end
                            end else begin
                                count_q <= count_q - ONE;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_down_counter.sv
// Scoreboard bench for down_counter: expected count/tc/busy queued per edge.
// Covers reset, one-shot, auto-reload, enable gaps, load priority, full range.
module tb_down_counter;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] count;
        logic             tc;
        logic             busy;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];

    down_counter_if #(.WIDTH(WIDTH)) bus ();

    down_counter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp,
                     $time);
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty got 0 expected 1", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".count"}, 32'(bus.count), 32'(e.count));
            check({tag, ".tc"}, 32'(bus.tc), 32'(e.tc));
            check({tag, ".busy"}, 32'(bus.busy), 32'(e.busy));
        end
    endtask

    // Drive one edge worth of inputs and the outputs expected after it.
    task automatic step(input string tag, input logic ld,
                        input logic [WIDTH-1:0] val, input logic en,
                        input logic ar, input logic [WIDTH-1:0] ec,
                        input logic etc, input logic eb);
        exp_t e;
        bus.load        = ld;
        bus.load_val    = val;
        bus.en          = en;
        bus.auto_reload = ar;
        e.count = ec;
        e.tc    = etc;
        e.busy  = eb;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        rst             = 1'b0;
        bus.load        = 1'b0;
        bus.load_val    = '0;
        bus.en          = 1'b0;
        bus.auto_reload = 1'b0;

        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst.count", 32'(bus.count), 0);
        check("rst.tc", 32'(bus.tc), 0);
        check("rst.busy", 32'(bus.busy), 0);
        rst = 1'b0;

        // Async reset while running at count 3.
        step("t1.load", 1, 3, 0, 0, 3, 0, 1);
        #3 rst = 1'b1;
        #1;
        check("t1.async.count", 32'(bus.count), 0);
        check("t1.async.busy", 32'(bus.busy), 0);
        check("t1.async.tc", 32'(bus.tc), 0);
        @(posedge clk);
        #1;
        check("t1.hold.count", 32'(bus.count), 0);
        check("t1.hold.busy", 32'(bus.busy), 0);
        rst = 1'b0;
        step("t1.post0", 0, 0, 1, 0, 0, 0, 0);
        step("t1.post1", 0, 0, 1, 0, 0, 0, 0);

        // One-shot from 5.
        step("t2.load", 1, 5, 0, 0, 5, 0, 1);
        for (int i = 4; i >= 1; i--)
            step("t2.run", 0, 0, 1, 0, WIDTH'(i), 0, 1);
        step("t2.tc", 0, 0, 1, 0, 0, 1, 0);
        step("t2.stop0", 0, 0, 1, 0, 0, 0, 0);
        step("t2.stop1", 0, 0, 1, 0, 0, 0, 0);

        // Auto-reload period 3; load wins over en on the same edge.
        step("t3.load", 1, 3, 1, 1, 3, 0, 1);
        for (int k = 0; k < 3; k++) begin
            step("t3.c2", 0, 0, 1, 1, 2, 0, 1);
            step("t3.c1", 0, 0, 1, 1, 1, 0, 1);
            step("t3.rl", 0, 0, 1, 1, 3, 1, 1);
        end

        // Enable gaps.
        step("t4.load", 1, 2, 0, 0, 2, 0, 1);
        step("t4.e1", 0, 0, 1, 0, 1, 0, 1);
        step("t4.e0a", 0, 0, 0, 0, 1, 0, 1);
        step("t4.e0b", 0, 0, 0, 0, 1, 0, 1);
        step("t4.tc", 0, 0, 1, 0, 0, 1, 0);
        step("t4.idle", 0, 0, 0, 0, 0, 0, 0);

        // Load on the terminal edge suppresses tc; load of 0 goes idle.
        step("t5.load", 1, 2, 0, 0, 2, 0, 1);
        step("t5.c1", 0, 0, 1, 0, 1, 0, 1);
        step("t5.ld9", 1, 9, 1, 0, 9, 0, 1);
        step("t5.ld0", 1, 0, 1, 0, 0, 0, 0);
        step("t5.en", 0, 0, 1, 0, 0, 0, 0);

        // Only the auto_reload value on the terminal edge matters.
        step("t7.load", 1, 2, 0, 0, 2, 0, 1);
        step("t7.c1", 0, 0, 1, 0, 1, 0, 1);
        step("t7.rl", 0, 0, 1, 1, 2, 1, 1);
        step("t7.c1b", 0, 0, 1, 1, 1, 0, 1);
        step("t7.os", 0, 0, 1, 0, 0, 1, 0);

        // Full-range one-shot from 255.
        step("t6.load", 1, 255, 0, 0, 255, 0, 1);
        for (int i = 254; i >= 1; i--)
            step("t6.run", 0, 0, 1, 0, WIDTH'(i), 0, 1);
        step("t6.tc", 0, 0, 1, 0, 0, 1, 0);
        step("t6.nowrap0", 0, 0, 1, 0, 0, 0, 0);
        step("t6.nowrap1", 0, 0, 1, 0, 0, 0, 0);

        check("sb.empty", 32'(sb_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Loadable, enable-gated down counter/timer; the counting-down counterpart of the team's 8-bit up counter.
- Software or an upstream FSM loads a start value. The block then decrements once per enabled clock.
- On reaching the end of a run it flags terminal count with a one-cycle pulse, then either stops (one-shot) or reloads and runs again (auto-reload).
- Used as a programmable delay or period generator beside the up counter.

Parameters:
WIDTH, 8, width of count, load_val and the internal reload register

Ports:
clk  input  1  rising-edge clock; the only clock
rst  input  1  reset; asynchronous, active-high; clears all state immediately, independent of clk
load  input  1  load request; sampled on the clk rising edge
load_val  input  WIDTH  start/reload value, captured when load=1
en  input  1  count enable; one decrement per clock while high in RUN
auto_reload  input  1  mode select: 1 = reload on terminal count, 0 = one-shot; sampled on the terminal cycle
count  output  WIDTH  current count value, registered
tc  output  1  terminal-count pulse, registered, one cycle wide
busy  output  1  high while in RUN, registered

Behaviour:
- Reset (rst=1, asynchronous) forces:
  - count=0, reload register=0, tc=0, busy=0, state=IDLE.
  - All of this holds for as long as rst is high.
  - On the first clk edge after rst falls, normal operation resumes.
- All outputs are flops. There is no combinational path from any input to any output.
- States:
  - IDLE (busy=0): en is ignored; count holds its value.
  - RUN (busy=1): count decrements under en.
- Load has the highest priority below reset, in any state:
  - On an edge with load=1: count<=load_val and reload<=load_val.
  - If load_val!=0: state<=RUN. If load_val==0: state<=IDLE.
  - tc<=0 on a load edge, even if en=1 and count==1 on the same edge. Load discards any pending terminal count.
- RUN, load=0, en=1, count>1: count<=count-1; tc<=0.
- RUN, load=0, en=1, count==1 (terminal edge): tc<=1 for exactly one cycle, then
  - auto_reload=1: count<=reload, state stays RUN. Count skips 0, so the period is exactly reload enabled cycles.
  - auto_reload=0: count<=0, state<=IDLE, busy<=0.
- RUN, en=0: count, state and busy hold; tc<=0.
- tc is high in the cycle immediately after the terminal edge. In that cycle count already shows 0 (one-shot) or the reload value (auto-reload).
- Arithmetic: unsigned, modulo 2^WIDTH.
  - count never underflows: 0 is not decremented, because RUN is never entered with count 0 and exits at 1.
  - A load_val of 2^WIDTH-1 gives the maximum run of 2^WIDTH-1 enabled cycles.
- If auto_reload changes mid-run, only its value on the terminal edge matters.
- Reset mid-run: count, tc and busy clear asynchronously, with no completion pulse.

Test Plan:
1. Assert rst asynchronously (between edges) while count=3 in RUN -> count=0, busy=0, tc=0 before the next clk edge; holds through rst; after release with load=0, en=1, count stays 0 and busy stays 0.
2. load_val=5, auto_reload=0, load one cycle then en held high -> count 5,4,3,2,1,0 on successive cycles; tc=1 only in the cycle count shows 0; busy 1 from the load until that same cycle, then 0; count stays 0 with en still high.
3. load_val=3, auto_reload=1, en held high -> count 3,2,1,3,2,1,3…; tc pulses every 3rd cycle, each coinciding with count=3 after reload; busy stays 1.
4. load_val=2, en pattern 1,0,0,1 -> count 2,1,1,1,0; tc pulses only after the 4th edge.
5. In RUN with count=1, assert load=1 with load_val=9 and en=1 on the same edge -> count=9, tc stays 0, busy=1. Then load_val=0 with load=1 -> count=0, busy=0, no tc; en=1 afterwards leaves count at 0.
6. WIDTH=8, load_val=255, auto_reload=0, en high -> 255 enabled cycles to reach 0; exactly one tc; no wrap to 255.
